// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial WIDTH-bit subtract sequencer built around one external 1-bit
//   full subtractor. Operands are latched on an accepted start, walked
//   LSB-first through the cell one bit per clock with the borrow fed back,
//   and the difference plus final borrow are collected and held.
//
//   Ports
//     clk, rst_n         clock (rising edge), asynchronous active-low reset
//     start              request, sampled only while idle
//     a, b, bin          minuend, subtrahend, initial borrow (captured on start)
//     busy               high while an operation is in progress (RUN or DONE)
//     done               one-cycle pulse, diff/bout valid
//     diff, bout         result a - b - bin (mod 2^WIDTH) and final borrow
//     fs_a, fs_b, fs_bin operand/borrow bits to the full subtractor
//     fs_d, fs_bout      difference/borrow bits back from the full subtractor
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_d,
    input  logic             fs_bout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr_a;
    logic [WIDTH-1:0]   r_sr_b;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;
    logic               w_last_bit;

    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    // Sequencer: state, operand shifters, borrow feedback and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sr_a  <= '0;
            r_sr_b  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sr_a  <= a;
                        r_sr_b  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_diff <= {fs_d, r_diff[WIDTH-1:1]};
                    // Zero fill: after WIDTH shifts the shifters are all-zero,
                    // so fs_a/fs_b read 0 outside RUN without extra gating.
                    r_sr_a <= r_sr_a >> 1;
                    r_sr_b <= r_sr_b >> 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        r_bout  <= fs_bout;
                        r_brw   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_brw <= fs_bout;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cell inputs come straight from register bits: no combinational loop
    // through the external subtractor.
    assign fs_a   = r_sr_a[0];
    assign fs_b   = r_sr_b[0];
    assign fs_bin = r_brw;

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
